cpu_program_loader: RTL and testbench

Parametrised program/data loader and run controller for the pipelined CPU. It accepts a stream of (address, word) pairs over a valid/ready handshake and writes them into the CPU memory write port (`w_enable`/`w_adrs`/`w_instruction`). After the last word it asserts `cpu_en` for a programmed number of cycles, then captures `result`/`carry`. It sits between a host/bench stimulus source and `top_level`, replacing hand-sequenced memory writes.

---
 rtl/cpu_program_loader.sv | 174 +++++++++++++++++
 tb/tb_cpu_program_loader.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_program_loader.sv
// cpu_program_loader: streams (address, word) pairs into the CPU memory write
// port, then runs the CPU for a programmed number of cycles and captures the
// resulting result/carry.
// Optional feature macro: LOADER_CHECKSUM_EN adds a running XOR checksum output
// over every accepted word since the last return to IDLE.
module cpu_program_loader #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 11,
    parameter int RUN_W  = 16
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [ADDR_W-1:0] in_adrs,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_last,
    input  logic [RUN_W-1:0]  run_cycles,
    input  logic              abort,
    input  logic              done_ack,
    output logic              w_enable,
    output logic [ADDR_W-1:0] w_adrs,
    output logic [DATA_W-1:0] w_instruction,
    output logic              cpu_en,
    input  logic [DATA_W-1:0] cpu_result,
    input  logic              cpu_carry,
    output logic [DATA_W-1:0] cap_result,
    output logic              cap_carry,
    output logic              done,
    output logic              busy,
`ifdef LOADER_CHECKSUM_EN
    output logic [DATA_W-1:0] checksum,
`endif
    output logic [ADDR_W:0]   word_count
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_DONE
    } state_t;

    localparam logic [ADDR_W:0] WORD_COUNT_MAX = {1'b1, {ADDR_W{1'b0}}};

    state_t           state;
    state_t           state_next;
    logic             accept;
    logic             enter_idle;
    logic [RUN_W-1:0] run_cnt;

    // State register; everything restarts in IDLE on reset.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state, handshake and status decode; abort overrides every other transition.
    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        busy       = 1'b1;
        done       = 1'b0;
        accept     = 1'b0;
        case (state)
            S_IDLE: begin
                busy     = 1'b0;
                in_ready = 1'b1;
                if (in_valid) begin
                    accept     = 1'b1;
                    state_next = in_last ? S_RUN : S_LOAD;
                end
            end
            S_LOAD: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    accept = 1'b1;
                    if (in_last) begin
                        state_next = S_RUN;
                    end
                end
            end
            S_RUN: begin
                if (run_cnt == '0) begin
                    state_next = S_DONE;
                end
            end
            S_DONE: begin
                done = 1'b1;
                if (done_ack) begin
                    state_next = S_IDLE;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
        if (abort) begin
            state_next = S_IDLE;
            accept     = 1'b0;
        end
        enter_idle = (state_next == S_IDLE) && (state != S_IDLE);
    end

    // Memory write port: each accepted word becomes a single write strobe one cycle later.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            w_enable      <= 1'b0;
            w_adrs        <= '0;
            w_instruction <= '0;
        end else begin
            w_enable <= accept;
            if (accept) begin
                w_adrs        <= in_adrs;
                w_instruction <= in_data;
            end
        end
    end

    // Run counter and CPU enable: cpu_en is registered so it starts only after the final write cycle.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            run_cnt <= '0;
            cpu_en  <= 1'b0;
        end else begin
            cpu_en <= 1'b0;
            if (accept && in_last) begin
                run_cnt <= run_cycles;
            end else if ((state == S_RUN) && !abort && (run_cnt != '0)) begin
                cpu_en  <= 1'b1;
                run_cnt <= run_cnt - 1'b1;
            end
        end
    end

    // Result capture at the edge that closes the last run cycle (or immediately for a zero-length run).
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cap_result <= '0;
            cap_carry  <= 1'b0;
        end else if ((state == S_RUN) && (run_cnt == '0) && !abort) begin
            cap_result <= cpu_result;
            cap_carry  <= cpu_carry;
        end
    end

    // Saturating count of words written since the last return to IDLE.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            word_count <= '0;
        end else if (enter_idle) begin
            word_count <= '0;
        end else if (accept && (word_count != WORD_COUNT_MAX)) begin
            word_count <= word_count + 1'b1;
        end
    end

`ifdef LOADER_CHECKSUM_EN
    // Running XOR of accepted words, cleared whenever the loader returns to IDLE.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            checksum <= '0;
        end else if (enter_idle) begin
            checksum <= '0;
        end else if (accept) begin
            checksum <= checksum ^ in_data;
        end
    end
`endif

endmodule

// File: tb/tb_cpu_program_loader.sv
// tb_cpu_program_loader: directed self-checking bench for cpu_program_loader.
// Define LOADER_CHECKSUM_EN to also exercise the checksum output.
module tb_cpu_program_loader;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 11;
    localparam int RUN_W  = 16;

    logic              clk = 1'b0;
    logic              resetn;
    logic              in_valid;
    logic              in_ready;
    logic [ADDR_W-1:0] in_adrs;
    logic [DATA_W-1:0] in_data;
    logic              in_last;
    logic [RUN_W-1:0]  run_cycles;
    logic              abort;
    logic              done_ack;
    logic              w_enable;
    logic [ADDR_W-1:0] w_adrs;
    logic [DATA_W-1:0] w_instruction;
    logic              cpu_en;
    logic [DATA_W-1:0] cpu_result;
    logic              cpu_carry;
    logic [DATA_W-1:0] cap_result;
    logic              cap_carry;
    logic              done;
    logic              busy;
    logic [ADDR_W:0]   word_count;
`ifdef LOADER_CHECKSUM_EN
    logic [DATA_W-1:0] checksum;
`endif

    int tests_run    = 0;
    int tests_failed = 0;

    cpu_program_loader #(
        .DATA_W(DATA_W),
        .ADDR_W(ADDR_W),
        .RUN_W (RUN_W)
    ) dut (
        .clk          (clk),
        .resetn       (resetn),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_adrs      (in_adrs),
        .in_data      (in_data),
        .in_last      (in_last),
        .run_cycles   (run_cycles),
        .abort        (abort),
        .done_ack     (done_ack),
        .w_enable     (w_enable),
        .w_adrs       (w_adrs),
        .w_instruction(w_instruction),
        .cpu_en       (cpu_en),
        .cpu_result   (cpu_result),
        .cpu_carry    (cpu_carry),
        .cap_result   (cap_result),
        .cap_carry    (cap_carry),
        .done         (done),
        .busy         (busy),
`ifdef LOADER_CHECKSUM_EN
        .checksum     (checksum),
`endif
        .word_count   (word_count)
    );

    // Free-running clock, 10 time units per period.
    always #5 clk = ~clk;

    task automatic test_reset();
        resetn     = 1'b0;
        in_valid   = 1'b0;
        in_adrs    = '0;
        in_data    = '0;
        in_last    = 1'b0;
        run_cycles = '0;
        abort      = 1'b0;
        done_ack   = 1'b0;
        cpu_result = '0;
        cpu_carry  = 1'b0;
        repeat (3) @(negedge clk);
        tests_run++;
        if (in_ready !== 1'b1) begin tests_failed++; $display("[TB] FAIL reset_in_ready: got %b expected 1", in_ready); end
        tests_run++;
        if ({w_enable, cpu_en, done, busy} !== 4'b0000) begin tests_failed++; $display("[TB] FAIL reset_ctrl: got %b expected 0000", {w_enable, cpu_en, done, busy}); end
        tests_run++;
        if (cap_result !== 32'h0 || cap_carry !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_capture: got %h/%b expected 0/0", cap_result, cap_carry); end
        tests_run++;
        if (word_count !== 12'd0) begin tests_failed++; $display("[TB] FAIL reset_word_count: got %0d expected 0", word_count); end
`ifdef LOADER_CHECKSUM_EN
        tests_run++;
        if (checksum !== 32'h0) begin tests_failed++; $display("[TB] FAIL reset_checksum: got %h expected 0", checksum); end
`endif
        resetn = 1'b1;
    endtask

    task automatic test_load_run();
        logic [ADDR_W-1:0] adrs_tab [5];
        logic [DATA_W-1:0] data_tab [5];
        int en_cycles;
        adrs_tab = '{11'd1, 11'd4, 11'd12, 11'd15, 11'd17};
        data_tab = '{32'hE000_300F, 32'hE0A2_8A31, 32'h2000_1CA5, 32'hFFFF_0000, 32'hAAAA_AAAA};
        en_cycles = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (i > 0) begin
                tests_run++;
                if (w_enable !== 1'b1 || w_adrs !== adrs_tab[i-1] || w_instruction !== data_tab[i-1]) begin
                    tests_failed++;
                    $display("[TB] FAIL load_write%0d: got en=%b adrs=%0d data=%h expected en=1 adrs=%0d data=%h", i-1, w_enable, w_adrs, w_instruction, adrs_tab[i-1], data_tab[i-1]);
                end
            end
            tests_run++;
            if (in_ready !== 1'b1) begin tests_failed++; $display("[TB] FAIL load_ready%0d: got %b expected 1", i, in_ready); end
            in_valid   = 1'b1;
            in_adrs    = adrs_tab[i];
            in_data    = data_tab[i];
            in_last    = (i == 4);
            run_cycles = 16'd30;
        end
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
        tests_run++;
        if (w_enable !== 1'b1 || w_adrs !== adrs_tab[4] || w_instruction !== data_tab[4] || cpu_en !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL load_write4: got en=%b adrs=%0d data=%h cpu_en=%b expected en=1 adrs=17 data=aaaaaaaa cpu_en=0", w_enable, w_adrs, w_instruction, cpu_en);
        end
        tests_run++;
        if (word_count !== 12'd5) begin tests_failed++; $display("[TB] FAIL load_word_count: got %0d expected 5", word_count); end
        for (int c = 1; c <= 31; c++) begin
            @(negedge clk);
            cpu_result = 32'hC0DE_0000 + c;
            cpu_carry  = (c == 30);
            if (cpu_en === 1'b1) en_cycles++;
            if (c <= 30) begin
                tests_run++;
                if (cpu_en !== 1'b1 || w_enable !== 1'b0 || done !== 1'b0) begin
                    tests_failed++;
                    $display("[TB] FAIL run_cycle%0d: got cpu_en=%b w_en=%b done=%b expected 1/0/0", c, cpu_en, w_enable, done);
                end
            end
        end
        tests_run++;
        if (en_cycles != 30) begin tests_failed++; $display("[TB] FAIL run_length: got %0d expected 30", en_cycles); end
        tests_run++;
        if (done !== 1'b1 || cpu_en !== 1'b0 || in_ready !== 1'b0 || busy !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL run_done: got done=%b cpu_en=%b in_ready=%b busy=%b expected 1/0/0/1", done, cpu_en, in_ready, busy);
        end
        tests_run++;
        if (cap_result !== 32'hC0DE_001E || cap_carry !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL run_capture: got %h/%b expected c0de001e/1", cap_result, cap_carry);
        end
    endtask

    task automatic test_backpressure();
        in_valid = 1'b1;
        in_adrs  = 11'd5;
        in_data  = 32'h1234_5678;
        in_last  = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            tests_run++;
            if (w_enable !== 1'b0 || in_ready !== 1'b0 || done !== 1'b1) begin
                tests_failed++;
                $display("[TB] FAIL bp_hold%0d: got w_en=%b in_ready=%b done=%b expected 0/0/1", k, w_enable, in_ready, done);
            end
        end
        done_ack = 1'b1;
        @(negedge clk);
        done_ack = 1'b0;
        tests_run++;
        if (done !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1 || w_enable !== 1'b0 || word_count !== 12'd0) begin
            tests_failed++;
            $display("[TB] FAIL bp_ack_idle: got done=%b busy=%b in_ready=%b w_en=%b wc=%0d expected 0/0/1/0/0", done, busy, in_ready, w_enable, word_count);
        end
        tests_run++;
        if (cap_result !== 32'hC0DE_001E) begin tests_failed++; $display("[TB] FAIL bp_cap_held: got %h expected c0de001e", cap_result); end
        @(negedge clk);
        in_valid = 1'b0;
        tests_run++;
        if (w_enable !== 1'b1 || w_adrs !== 11'd5 || w_instruction !== 32'h1234_5678 || word_count !== 12'd1) begin
            tests_failed++;
            $display("[TB] FAIL bp_accept: got en=%b adrs=%0d data=%h wc=%0d expected 1/5/12345678/1", w_enable, w_adrs, w_instruction, word_count);
        end
    endtask

    task automatic test_abort();
        @(negedge clk);
        in_valid = 1'b1;
        in_adrs  = 11'd6;
        in_data  = 32'h0F0F_0F0F;
        in_last  = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        abort    = 1'b1;
        tests_run++;
        if (w_enable !== 1'b1 || w_adrs !== 11'd6 || word_count !== 12'd2) begin
            tests_failed++;
            $display("[TB] FAIL abort_pre: got en=%b adrs=%0d wc=%0d expected 1/6/2", w_enable, w_adrs, word_count);
        end
`ifdef LOADER_CHECKSUM_EN
        tests_run++;
        if (checksum !== 32'h1D3B_5977) begin tests_failed++; $display("[TB] FAIL abort_checksum_pre: got %h expected 1d3b5977", checksum); end
`endif
        @(negedge clk);
        abort = 1'b0;
        tests_run++;
        if (busy !== 1'b0 || word_count !== 12'd0 || w_enable !== 1'b0 || cpu_en !== 1'b0 || done !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL abort_idle: got busy=%b wc=%0d w_en=%b cpu_en=%b done=%b expected 0/0/0/0/0", busy, word_count, w_enable, cpu_en, done);
        end
        tests_run++;
        if (cap_result !== 32'hC0DE_001E) begin tests_failed++; $display("[TB] FAIL abort_cap_held: got %h expected c0de001e", cap_result); end
`ifdef LOADER_CHECKSUM_EN
        tests_run++;
        if (checksum !== 32'h0) begin tests_failed++; $display("[TB] FAIL abort_checksum_clear: got %h expected 0", checksum); end
`endif
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            tests_run++;
            if (cpu_en !== 1'b0 || busy !== 1'b0) begin tests_failed++; $display("[TB] FAIL abort_quiet%0d: got cpu_en=%b busy=%b expected 0/0", k, cpu_en, busy); end
        end
    endtask

    task automatic test_zero_run();
        @(negedge clk);
        in_valid   = 1'b1;
        in_adrs    = 11'd7;
        in_data    = 32'hDEAD_BEEF;
        in_last    = 1'b1;
        run_cycles = 16'd0;
        cpu_result = 32'h0BAD_F00D;
        cpu_carry  = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
        tests_run++;
        if (w_enable !== 1'b1 || w_adrs !== 11'd7 || w_instruction !== 32'hDEAD_BEEF || cpu_en !== 1'b0 || done !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL zero_write: got en=%b adrs=%0d data=%h cpu_en=%b done=%b expected 1/7/deadbeef/0/0", w_enable, w_adrs, w_instruction, cpu_en, done);
        end
        @(negedge clk);
        tests_run++;
        if (done !== 1'b1 || cpu_en !== 1'b0 || w_enable !== 1'b0 || word_count !== 12'd1) begin
            tests_failed++;
            $display("[TB] FAIL zero_done: got done=%b cpu_en=%b w_en=%b wc=%0d expected 1/0/0/1", done, cpu_en, w_enable, word_count);
        end
        tests_run++;
        if (cap_result !== 32'h0BAD_F00D || cap_carry !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL zero_capture: got %h/%b expected 0badf00d/0", cap_result, cap_carry);
        end
        done_ack = 1'b1;
        @(negedge clk);
        done_ack = 1'b0;
        tests_run++;
        if (done !== 1'b0 || busy !== 1'b0) begin tests_failed++; $display("[TB] FAIL zero_ack: got done=%b busy=%b expected 0/0", done, busy); end
    endtask

`ifdef LOADER_CHECKSUM_EN
    task automatic test_checksum();
        @(negedge clk);
        in_valid   = 1'b1;
        in_adrs    = 11'd15;
        in_data    = 32'hFFFF_0000;
        in_last    = 1'b0;
        @(negedge clk);
        in_adrs    = 11'd17;
        in_data    = 32'hAAAA_AAAA;
        in_last    = 1'b1;
        run_cycles = 16'd2;
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
        repeat (3) @(negedge clk);
        tests_run++;
        if (done !== 1'b1 || checksum !== 32'h5555_AAAA) begin
            tests_failed++;
            $display("[TB] FAIL checksum_done: got done=%b checksum=%h expected 1/5555aaaa", done, checksum);
        end
        done_ack = 1'b1;
        @(negedge clk);
        done_ack = 1'b0;
        tests_run++;
        if (checksum !== 32'h0) begin tests_failed++; $display("[TB] FAIL checksum_idle_clear: got %h expected 0", checksum); end
    endtask
`endif

    task automatic test_reset_mid_run();
        @(negedge clk);
        in_valid   = 1'b1;
        in_adrs    = 11'd3;
        in_data    = 32'h5A5A_5A5A;
        in_last    = 1'b1;
        run_cycles = 16'd20;
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
        repeat (5) @(negedge clk);
        tests_run++;
        if (cpu_en !== 1'b1) begin tests_failed++; $display("[TB] FAIL midrun_running: got cpu_en=%b expected 1", cpu_en); end
        #2;
        resetn = 1'b0;
        #1;
        tests_run++;
        if (cpu_en !== 1'b0 || done !== 1'b0 || in_ready !== 1'b1 || w_enable !== 1'b0 || busy !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL midrun_reset: got cpu_en=%b done=%b in_ready=%b w_en=%b busy=%b expected 0/0/1/0/0", cpu_en, done, in_ready, w_enable, busy);
        end
        tests_run++;
        if (cap_result !== 32'h0) begin tests_failed++; $display("[TB] FAIL midrun_cap_reset: got %h expected 0", cap_result); end
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
    endtask

    // Scenario sequence followed by the single summary line.
    initial begin
        test_reset();
        test_load_run();
        test_backpressure();
        test_abort();
        test_zero_run();
`ifdef LOADER_CHECKSUM_EN
        test_checksum();
`endif
        test_reset_mid_run();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
